// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   - FSM state encoding for the command sequencer
//   - default memory address/data widths
//   - port index constants used by the grant logic and owner tracking
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the memory-side bus.
//   req0_* / req1_* : valid/rwn/addr/wdata in, ready/rvalid/rdata out (port0 = ifetch, port1 = lsu)
//   mem_*           : start/rwn/address/data_in towards memory, data_out back from memory
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters plus memory)
interface mem_arbiter_if import mem_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              req0_valid;
   logic              req0_rwn;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req0_rvalid;
   logic [DATA_W-1:0] req0_rdata;

   logic              req1_valid;
   logic              req1_rwn;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              req1_rvalid;
   logic [DATA_W-1:0] req1_rdata;

   logic              mem_start;
   logic              mem_rwn;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  req0_valid, req0_rwn, req0_addr, req0_wdata,
      output req0_ready, req0_rvalid, req0_rdata,
      input  req1_valid, req1_rwn, req1_addr, req1_wdata,
      output req1_ready, req1_rvalid, req1_rdata,
      output mem_start, mem_rwn, mem_address, mem_data_in,
      input  mem_data_out
   );

   modport master (
      output req0_valid, req0_rwn, req0_addr, req0_wdata,
      input  req0_ready, req0_rvalid, req0_rdata,
      output req1_valid, req1_rwn, req1_addr, req1_wdata,
      input  req1_ready, req1_rvalid, req1_rdata,
      input  mem_start, mem_rwn, mem_address, mem_data_in,
      output mem_data_out
   );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input grant logic for the memory arbiter.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   req_i[1:0]   request valids, bit N = port N
//   accept_i     a grant is being taken this cycle
//   gnt_vld_o    at least one request present
//   gnt_o        granted port index (PORT0/PORT1)
// Build option ARB_FIXED_PRIO_EN: when defined, port0 always wins ties and no
// last_grant state exists. Default is round-robin on ties.
module rr_arbiter2 import mem_arb_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic       gnt_vld_o,
   output logic       gnt_o
);

   assign gnt_vld_o = |req_i;

`ifdef ARB_FIXED_PRIO_EN
   logic unused_fixed;
   assign unused_fixed = &{1'b0, clk, reset, accept_i};

   always_comb begin
      gnt_o = req_i[0] ? PORT0 : PORT1;
   end
`else
   logic last_grant_q;
   logic last_grant_d;

   // Toggles on every accept; a tie goes to the port opposite last_grant.
   assign last_grant_d = accept_i ? ~last_grant_q : last_grant_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= PORT1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      gnt_o = PORT0;
      if (&req_i) begin
         gnt_o = ~last_grant_q;
      end else if (req_i[1]) begin
         gnt_o = PORT1;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises read/write commands from two requesters onto a
// single-port synchronous memory and routes read data back to the owner.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; drops any in-flight command
//   bus    mem_arbiter_if.slave (requester handshakes and memory bus)
// Latency: accept at T, mem_start at T+1, rvalid at T+3.
// Build option ARB_FIXED_PRIO_EN selects fixed port0 priority in rr_arbiter2.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting; ready pulses to the granted port on accept
// ST_ISSUE   | mem_start high, command regs drive the memory
// ST_CAPTURE | memory read data loaded into owner's rdata register
// ST_RESP    | rvalid high for the owner
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   state_t            state_q;
   logic              mem_start_q;
   logic              mem_rwn_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic [DATA_W-1:0] mem_data_in_q;
   logic              owner_q;
   logic              rvalid0_q;
   logic              rvalid1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   logic [1:0]        req_vld;
   logic              gnt_vld;
   logic              gnt_port;
   logic              accept;
   logic              sel_rwn;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req_vld = {bus.req1_valid, bus.req0_valid};
   assign accept  = (state_q == ST_IDLE) && gnt_vld;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req_vld),
      .accept_i  (accept),
      .gnt_vld_o (gnt_vld),
      .gnt_o     (gnt_port)
   );

   assign sel_rwn   = (gnt_port == PORT1) ? bus.req1_rwn   : bus.req0_rwn;
   assign sel_addr  = (gnt_port == PORT1) ? bus.req1_addr  : bus.req0_addr;
   assign sel_wdata = (gnt_port == PORT1) ? bus.req1_wdata : bus.req0_wdata;

   assign bus.req0_ready = accept && (gnt_port == PORT0);
   assign bus.req1_ready = accept && (gnt_port == PORT1);

   // The memory-side registers double as the latched command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         mem_start_q   <= 1'b0;
         mem_rwn_q     <= 1'b1;
         mem_address_q <= '0;
         mem_data_in_q <= '0;
         owner_q       <= PORT0;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  mem_start_q   <= 1'b1;
                  mem_rwn_q     <= sel_rwn;
                  mem_address_q <= sel_addr;
                  mem_data_in_q <= sel_wdata;
                  owner_q       <= gnt_port;
                  state_q       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_start_q <= 1'b0;
               state_q     <= mem_rwn_q ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
               if (owner_q == PORT1) begin
                  rdata1_q  <= bus.mem_data_out;
                  rvalid1_q <= 1'b1;
               end else begin
                  rdata0_q  <= bus.mem_data_out;
                  rvalid0_q <= 1'b1;
               end
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               rvalid0_q <= 1'b0;
               rvalid1_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_start   = mem_start_q;
   assign bus.mem_rwn     = mem_rwn_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.req0_rvalid = rvalid0_q;
   assign bus.req1_rvalid = rvalid1_q;
   assign bus.req0_rdata  = rdata0_q;
   assign bus.req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// word memory, a per-port read-data scoreboard and a cycle-level
// grant/strobe/latency model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [7:0] a);
      return 32'h5A00_0000 ^ ({24'd0, a} * 32'h0001_0203);
   endfunction

   // Behavioural memory: write on strobe, read data registered one cycle later.
   logic [31:0] mem_m [256];
   bit          wr_m  [256];
   always @(posedge clk) begin
      if (bus.mem_start) begin
         if (!bus.mem_rwn) begin
            mem_m[bus.mem_address[7:0]] <= bus.mem_data_in;
            wr_m[bus.mem_address[7:0]]  <= 1'b1;
         end else begin
            bus.mem_data_out <= wr_m[bus.mem_address[7:0]] ? mem_m[bus.mem_address[7:0]]
                                                            : init_word(bus.mem_address[7:0]);
         end
      end
   end

   // Reference contents, updated when a write is driven.
   logic [31:0] ref_mem [256];
   bit          ref_wr  [256];
   function automatic logic [31:0] ref_val(input logic [7:0] a);
      return ref_wr[a] ? ref_mem[a] : init_word(a);
   endfunction

   logic [31:0] exp_q [2][$];
   int          due_q [2][$];

   task automatic send(input int p, input logic rwn, input logic [15:0] a, input logic [31:0] d);
      bit got;
      got = 1'b0;
      if (rwn) exp_q[p].push_back(ref_val(a[7:0]));
      else begin
         ref_mem[a[7:0]] = d;
         ref_wr[a[7:0]]  = 1'b1;
      end
      if (p == 0) begin
         bus.req0_valid = 1'b1; bus.req0_rwn = rwn; bus.req0_addr = a; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_rwn = rwn; bus.req1_addr = a; bus.req1_wdata = d;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = (p == 0) ? bus.req0_ready : bus.req1_ready;
      end
      if (!got) check($sformatf("ready%0d_timeout", p), 64'd0, 64'd1);
      @(posedge clk);
      #1;
      if (p == 0) bus.req0_valid = 1'b0;
      else        bus.req1_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (due_q[0].size() + due_q[1].size()) > 0; i++) @(negedge clk);
      check("drain", 64'(due_q[0].size() + due_q[1].size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Cycle model: grant choice, busy window, strobe timing, rvalid timing.
   int          cyc = 0;
   logic        lg_m = 1'b1;
   int          busy = 0;
   bit          start_pend = 1'b0;
   logic        g;
   logic        p_rwn;
   logic [15:0] p_addr;
   logic [31:0] p_wdata;
   logic [1:0]  rdy;
   logic        rv;
   bit          due;
   logic [31:0] e;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         lg_m       = 1'b1;
         busy       = 0;
         start_pend = 1'b0;
         for (int p = 0; p < 2; p++) begin
            exp_q[p].delete();
            due_q[p].delete();
         end
         check("rst_start", 64'(bus.mem_start), 64'd0);
         check("rst_rvalid", 64'({bus.req1_rvalid, bus.req0_rvalid}), 64'd0);
      end else begin
         check("mem_start", 64'(bus.mem_start), 64'(start_pend));
         if (start_pend) begin
            check("mem_rwn", 64'(bus.mem_rwn), 64'(p_rwn));
            check("mem_address", 64'(bus.mem_address), 64'(p_addr));
            if (!p_rwn) check("mem_data_in", 64'(bus.mem_data_in), 64'(p_wdata));
         end
         start_pend = 1'b0;
         rdy = {bus.req1_ready, bus.req0_ready};
         if (busy > 0) begin
            check("ready_busy", 64'(rdy), 64'd0);
            busy--;
         end else if (bus.req0_valid || bus.req1_valid) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
               g = 1'b0;
`else
               g = ~lg_m;
`endif
            end else begin
               g = bus.req0_valid ? 1'b0 : 1'b1;
            end
            check("grant", 64'(rdy), g ? 64'd2 : 64'd1);
            lg_m    = ~lg_m;
            p_rwn   = g ? bus.req1_rwn   : bus.req0_rwn;
            p_addr  = g ? bus.req1_addr  : bus.req0_addr;
            p_wdata = g ? bus.req1_wdata : bus.req0_wdata;
            busy    = p_rwn ? 3 : 1;
            start_pend = 1'b1;
            if (p_rwn) due_q[g].push_back(cyc + 3);
         end else begin
            check("ready_idle", 64'(rdy), 64'd0);
         end
         for (int p = 0; p < 2; p++) begin
            rv  = (p == 0) ? bus.req0_rvalid : bus.req1_rvalid;
            due = (due_q[p].size() > 0) && (due_q[p][0] == cyc);
            check($sformatf("rvalid%0d", p), 64'(rv), 64'(due));
            if (due) begin
               void'(due_q[p].pop_front());
               if (exp_q[p].size() > 0) begin
                  e = exp_q[p].pop_front();
                  if (rv) check($sformatf("rdata%0d", p),
                                64'((p == 0) ? bus.req0_rdata : bus.req1_rdata), 64'(e));
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_rwn = 1'b1; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_valid = 1'b0; bus.req1_rwn = 1'b1; bus.req1_addr = '0; bus.req1_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_rwn", 64'(bus.mem_rwn), 64'd1);
      check("rst_mem_address", 64'(bus.mem_address), 64'd0);
      check("rst_mem_data_in", 64'(bus.mem_data_in), 64'd0);
      check("rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      check("rst_rdata0", 64'(bus.req0_rdata), 64'd0);
      check("rst_rdata1", 64'(bus.req1_rdata), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Write then read back on port0.
      send(0, 1'b0, 16'h0010, 32'hDEADBEEF);
      send(0, 1'b1, 16'h0010, 32'h0);
      drain();
      check("t1_rdata0", 64'(bus.req0_rdata), 64'hDEADBEEF);

      // Simultaneous reads on both ports.
      fork
         send(0, 1'b1, 16'h0001, 32'h0);
         send(1, 1'b1, 16'h0002, 32'h0);
      join
      drain();

      // Both ports streaming reads.
      fork
         begin
            for (int i = 0; i < 4; i++) send(0, 1'b1, 16'(16'h0020 + i), 32'h0);
         end
         begin
            for (int j = 0; j < 4; j++) send(1, 1'b1, 16'(16'h0030 + j), 32'h0);
         end
      join
      drain();

      // Port1 write observed by a later port0 read.
      send(1, 1'b0, 16'h00AA, 32'h12345678);
      send(0, 1'b1, 16'h00AA, 32'h0);
      drain();
      check("t4_rdata0", 64'(bus.req0_rdata), 64'h12345678);

      // Reset while a read is in CAPTURE.
      send(0, 1'b1, 16'h0040, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t5_start", 64'(bus.mem_start), 64'd0);
      check("t5_rvalid", 64'({bus.req1_rvalid, bus.req0_rvalid}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) @(negedge clk);
      send(1, 1'b1, 16'h0040, 32'h0);
      drain();
      check("t5_rdata1", 64'(bus.req1_rdata), 64'(init_word(8'h40)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
